true_dp_bram_ccnt: RTL and testbench

- True dual-port BRAM, both ports read/write, single clock, write-first on each port's own data path, 2-cycle read latency.
- Holds a per-entry saturating access counter of CNT_WIDTH bits, replacing the single read-since-set bit.
  - Port 2 reads increment the counter.
  - Port 1 reads return the counter alongside the data and can optionally clear it.
- Used by the register/cache tables to track reads since last update, for eviction and statistics.
- Adds a post-reset clear sweep of the counter memory.

---
 rtl/true_dp_bram_ccnt_pkg.sv | 29 ++
 rtl/true_dp_bram_ccnt_cram.sv | 109 ++++++++++
 rtl/true_dp_bram_ccnt.sv | 116 +++++++++++
 tb/tb_true_dp_bram_ccnt.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/true_dp_bram_ccnt_pkg.sv
// Shared definitions for the true dual-port BRAM with per-entry access counters.
//   state_e  : sweep/run state encoding
//   cmax     : largest value of a w-bit counter
//   sat_inc  : saturating increment of a w-bit counter (w <= MaxCntWidth)
package true_dp_bram_ccnt_pkg;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    localparam int unsigned MaxCntWidth = 16;

    function automatic logic [MaxCntWidth-1:0] cmax(input int unsigned w);
        return MaxCntWidth'((33'd1 << w) - 33'd1);
    endfunction

    // One extra bit of headroom so the carry out of the top bit is visible before clamping.
    function automatic logic [MaxCntWidth-1:0] sat_inc(input logic [MaxCntWidth-1:0] v,
                                                       input int unsigned            w);
        logic [MaxCntWidth:0] sum;
        sum = {1'b0, v} + (MaxCntWidth + 1)'(1);
        if (sum > {1'b0, cmax(w)}) begin
            sum = {1'b0, cmax(w)};
        end
        return sum[MaxCntWidth-1:0];
    endfunction

endpackage

// File: rtl/true_dp_bram_ccnt_cram.sv
// Counter RAM: one saturating access counter per entry, two read-modify-write ports.
// Each event reads at edge N and writes back at edge N+1; reads issued while a write-back
// is still pending see the pending value, so back-to-back events on one entry never lose
// updates. A separate sweep port zeroes entries during initialisation.
//   clk, rst              : clock, synchronous active-high reset
//   sweep_en, sweep_addr  : write 0 to the counter at sweep_addr
//   p1_en/we/clr/addr     : port 1 event; read samples the counter, clr/we zero it
//   p1_cnt                : port 1 stage-1 count (sampled value, 0 on a write)
//   p2_en/we/addr         : port 2 event; read increments, write zeroes
module true_dp_bram_ccnt_cram
    import true_dp_bram_ccnt_pkg::*;
#(
    parameter int unsigned L2_DEPTH  = 8,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sweep_en,
    input  logic [L2_DEPTH-1:0]  sweep_addr,
    input  logic                 p1_en,
    input  logic                 p1_we,
    input  logic                 p1_clr,
    input  logic [L2_DEPTH-1:0]  p1_addr,
    output logic [CNT_WIDTH-1:0] p1_cnt,
    input  logic                 p2_en,
    input  logic                 p2_we,
    input  logic [L2_DEPTH-1:0]  p2_addr
);

    localparam int unsigned Depth = 2 ** L2_DEPTH;

    typedef logic [L2_DEPTH-1:0]  addr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic cnt_t inc(input cnt_t v);
        return CNT_WIDTH'(sat_inc(MaxCntWidth'(v), CNT_WIDTH));
    endfunction

    cnt_t mem [Depth];

    // Events captured at edge N, written back at edge N+1.
    logic  v1_q, w1_q, c1_q, v2_q, w2_q;
    addr_t a1_q, a2_q;
    cnt_t  r2_q;

    logic  same;
    logic  wr1_en, wr2_en;
    cnt_t  wr2_val;
    cnt_t  rd1, rd2;

    assign same = v1_q && v2_q && (a1_q == a2_q);

    // Port 1 only ever writes zero. On a shared entry both events merge into one port 2 write.
    always_comb begin
        wr1_en  = v1_q && (w1_q || c1_q) && !same;
        wr2_en  = v2_q;
        wr2_val = w2_q ? '0 : inc(r2_q);
        if (same) begin
            if (w1_q || w2_q) begin
                wr2_val = '0;
            end else if (c1_q) begin
                wr2_val = inc('0);  // clear first, then count this cycle's port 2 read
            end
        end
    end

    // Forward the write-back happening at this edge into the reads sampled at this edge.
    always_comb begin
        rd1 = mem[p1_addr];
        if (wr1_en && (a1_q == p1_addr)) rd1 = '0;
        if (wr2_en && (a2_q == p1_addr)) rd1 = wr2_val;
        rd2 = mem[p2_addr];
        if (wr1_en && (a1_q == p2_addr)) rd2 = '0;
        if (wr2_en && (a2_q == p2_addr)) rd2 = wr2_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            w1_q   <= 1'b0;
            c1_q   <= 1'b0;
            a1_q   <= '0;
            v2_q   <= 1'b0;
            w2_q   <= 1'b0;
            a2_q   <= '0;
            r2_q   <= '0;
            p1_cnt <= '0;
        end else begin
            v1_q <= p1_en;
            w1_q <= p1_we;
            c1_q <= p1_clr;
            a1_q <= p1_addr;
            v2_q <= p2_en;
            w2_q <= p2_we;
            a2_q <= p2_addr;
            r2_q <= rd2;
            if (p1_en) begin
                p1_cnt <= p1_we ? '0 : rd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_en) mem[sweep_addr] <= '0;
        if (wr1_en)   mem[a1_q]       <= '0;
        if (wr2_en)   mem[a2_q]       <= wr2_val;
    end

endmodule

// File: rtl/true_dp_bram_ccnt.sv
// True dual-port BRAM, single clock, write-first per port, 2-cycle read latency, with a
// saturating per-entry access counter. Port 2 reads bump the counter; port 1 reads return
// it next to the data and may clear it. After reset the counter RAM is swept to zero and
// both ports are ignored until init_done rises.
//   clk, rst                          : clock, synchronous active-high reset
//   init_done                         : counter sweep finished, ports live
//   en1/we1/addr1/din1/clr1/regce1    : port 1 request, clear-on-read, output enable
//   dout1, cnt1                       : port 1 data and counter, aligned
//   en2/we2/addr2/din2/regce2         : port 2 request, output enable
//   dout2                             : port 2 data
module true_dp_bram_ccnt
    import true_dp_bram_ccnt_pkg::*;
#(
    parameter int unsigned L2_DEPTH  = 8,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_done,
    input  logic                 en1,
    input  logic                 we1,
    input  logic [L2_DEPTH-1:0]  addr1,
    input  logic [WIDTH-1:0]     din1,
    input  logic                 clr1,
    input  logic                 regce1,
    output logic [WIDTH-1:0]     dout1,
    output logic [CNT_WIDTH-1:0] cnt1,
    input  logic                 en2,
    input  logic                 we2,
    input  logic [L2_DEPTH-1:0]  addr2,
    input  logic [WIDTH-1:0]     din2,
    input  logic                 regce2,
    output logic [WIDTH-1:0]     dout2
);

    localparam int unsigned Depth = 2 ** L2_DEPTH;

    typedef logic [L2_DEPTH-1:0] addr_t;

    state_e               state_q;
    addr_t                ptr_q;
    logic                 acc1, acc2;
    logic                 sweep_en;
    logic [CNT_WIDTH-1:0] s1_cnt;
    logic [WIDTH-1:0]     s1_d1_q, s1_d2_q;
    logic [WIDTH-1:0]     ram [Depth];

    assign acc1     = en1 && init_done;
    assign acc2     = en2 && init_done;
    assign sweep_en = (state_q == StInit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            ptr_q     <= '0;
            init_done <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    ptr_q <= ptr_q + addr_t'(1);
                    if (ptr_q == addr_t'(Depth - 1)) begin
                        state_q   <= StRun;
                        init_done <= 1'b1;
                    end
                end
                StRun: begin
                end
            endcase
        end
    end

    true_dp_bram_ccnt_cram #(
        .L2_DEPTH (L2_DEPTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cram (
        .clk       (clk),
        .rst       (rst),
        .sweep_en  (sweep_en),
        .sweep_addr(ptr_q),
        .p1_en     (acc1),
        .p1_we     (we1),
        .p1_clr    (clr1),
        .p1_addr   (addr1),
        .p1_cnt    (s1_cnt),
        .p2_en     (acc2),
        .p2_we     (we2),
        .p2_addr   (addr2)
    );

    // Port 1 is written last so it wins a same-address write collision.
    always_ff @(posedge clk) begin
        if (acc2 && we2) ram[addr2] <= din2;
        if (acc1 && we1) ram[addr1] <= din1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_d1_q <= '0;
            s1_d2_q <= '0;
            dout1   <= '0;
            cnt1    <= '0;
            dout2   <= '0;
        end else begin
            if (acc1) s1_d1_q <= we1 ? din1 : ram[addr1];
            if (acc2) s1_d2_q <= we2 ? din2 : ram[addr2];
            if (regce1) begin
                dout1 <= s1_d1_q;
                cnt1  <= s1_cnt;
            end
            if (regce2) dout2 <= s1_d2_q;
        end
    end

endmodule

// File: tb/tb_true_dp_bram_ccnt.sv
module tb_true_dp_bram_ccnt;

    localparam int DEPTH = 16;
    localparam int CMAXA = 15;
    localparam int CMAXB = 3;

    logic        clk, rst;
    logic        en1, we1, clr1, regce1, en2, we2, regce2;
    logic [3:0]  addr1, addr2;
    logic [31:0] din1, din2;
    logic        done_a, done_b;
    logic [31:0] dout1_a, dout2_a, dout1_b, dout2_b;
    logic [3:0]  cnt1_a;
    logic [1:0]  cnt1_b;

    true_dp_bram_ccnt #(.L2_DEPTH(4), .WIDTH(32), .CNT_WIDTH(4), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst), .init_done(done_a),
        .en1(en1), .we1(we1), .addr1(addr1), .din1(din1), .clr1(clr1), .regce1(regce1),
        .dout1(dout1_a), .cnt1(cnt1_a),
        .en2(en2), .we2(we2), .addr2(addr2), .din2(din2), .regce2(regce2), .dout2(dout2_a)
    );

    true_dp_bram_ccnt #(.L2_DEPTH(4), .WIDTH(32), .CNT_WIDTH(2), .INIT_FILE("")) u_dut_sat (
        .clk(clk), .rst(rst), .init_done(done_b),
        .en1(en1), .we1(we1), .addr1(addr1), .din1(din1), .clr1(clr1), .regce1(regce1),
        .dout1(dout1_b), .cnt1(cnt1_b),
        .en2(en2), .we2(we2), .addr2(addr2), .din2(din2), .regce2(regce2), .dout2(dout2_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required $finish earlier", $time);
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int n, input int c);
        return (n > c) ? c : n;
    endfunction

    // Reference model: data words plus "reads since last update" as an unbounded count.
    logic [31:0] m_mem [DEPTH];
    bit          m_mv  [DEPTH];
    int          m_n   [DEPTH];
    bit          m_done;
    int          m_ctr;
    logic [31:0] s1d1, s1d2, od1, od2;
    bit          s1v1, s1v2, ov1, ov2;
    int          s1c, oc;

    task automatic tick();
        if (rst) begin
            m_done = 0; m_ctr = 0;
            s1d1 = 0; s1v1 = 1; s1c = 0; s1d2 = 0; s1v2 = 1;
            od1 = 0; ov1 = 1; oc = 0; od2 = 0; ov2 = 1;
            foreach (m_n[i]) m_n[i] = 0;
        end else begin
            if (regce1) begin od1 = s1d1; ov1 = s1v1; oc = s1c; end
            if (regce2) begin od2 = s1d2; ov2 = s1v2; end
            if (!m_done) begin
                m_ctr++;
                if (m_ctr == DEPTH) m_done = 1;
            end else begin
                if (en1) begin
                    if (we1) begin s1d1 = din1; s1v1 = 1; s1c = 0; end
                    else begin s1d1 = m_mem[addr1]; s1v1 = m_mv[addr1]; s1c = m_n[addr1]; end
                end
                if (en2) begin
                    if (we2) begin s1d2 = din2; s1v2 = 1; end
                    else begin s1d2 = m_mem[addr2]; s1v2 = m_mv[addr2]; end
                end
                if (en1 && !we1 && clr1) m_n[addr1] = 0;
                if (en2) m_n[addr2] = we2 ? 0 : m_n[addr2] + 1;
                if (en1 && we1) m_n[addr1] = 0;
                if (en2 && we2) begin m_mem[addr2] = din2; m_mv[addr2] = 1; end
                if (en1 && we1) begin m_mem[addr1] = din1; m_mv[addr1] = 1; end
            end
        end
        @(posedge clk);
        #1;
        chk("model_init_done_a", 32'(done_a), 32'(m_done));
        chk("model_init_done_b", 32'(done_b), 32'(m_done));
        chk("model_cnt1_a", 32'(cnt1_a), 32'(sat(oc, CMAXA)));
        chk("model_cnt1_b", 32'(cnt1_b), 32'(sat(oc, CMAXB)));
        if (ov1) begin
            chk("model_dout1_a", dout1_a, od1);
            chk("model_dout1_b", dout1_b, od1);
        end
        if (ov2) begin
            chk("model_dout2_a", dout2_a, od2);
            chk("model_dout2_b", dout2_b, od2);
        end
    endtask

    task automatic idle();
        en1 = 0; we1 = 0; clr1 = 0; addr1 = 0; din1 = 0;
        en2 = 0; we2 = 0; addr2 = 0; din2 = 0;
    endtask

    typedef struct {
        bit          e1, w1;
        logic [3:0]  a1;
        logic [31:0] d1;
        bit          c1, r1, e2, w2;
        logic [3:0]  a2;
        logic [31:0] d2;
        logic [3:0]  ck;    // {dout1, cnt1, cnt1 narrow, dout2}
        logic [31:0] ed1;
        logic [3:0]  ec1;
        logic [1:0]  ec1s;
        logic [31:0] ed2;
    } vec_t;

    function automatic vec_t mk(input bit e1, w1, input logic [3:0] a1, input logic [31:0] d1,
                                input bit c1, r1, e2, w2, input logic [3:0] a2,
                                input logic [31:0] d2, input logic [3:0] ck,
                                input logic [31:0] ed1, input logic [3:0] ec1,
                                input logic [1:0] ec1s, input logic [31:0] ed2);
        vec_t v;
        v.e1 = e1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.c1 = c1; v.r1 = r1;
        v.e2 = e2; v.w2 = w2; v.a2 = a2; v.d2 = d2;
        v.ck = ck; v.ed1 = ed1; v.ec1 = ec1; v.ec1s = ec1s; v.ed2 = ed2;
        return v;
    endfunction

    localparam int NV = 27;
    vec_t tbl [NV];

    initial begin
        int cyc;
        //            P1: en we a  din          clr rc  P2: en we a din       ck       dout1        cnt1 nar dout2
        tbl[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0,           4'b0000, 0,            0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,            0, 1, 1, 0, 5, 0,           4'b1110, 32'hDEADBEEF, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,            0, 1, 1, 0, 5, 0,           4'b0001, 0,            0, 0, 32'hDEADBEEF);
        tbl[3]  = mk(0, 0, 0, 0,            0, 1, 1, 0, 5, 0,           4'b0001, 0,            0, 0, 32'hDEADBEEF);
        tbl[4]  = mk(1, 0, 5, 0,            1, 1, 0, 0, 0, 0,           4'b0001, 0,            0, 0, 32'hDEADBEEF);
        tbl[5]  = mk(1, 0, 5, 0,            0, 1, 0, 0, 0, 0,           4'b1110, 32'hDEADBEEF, 3, 3, 0);
        tbl[6]  = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1110, 32'hDEADBEEF, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0,            0, 1, 1, 0, 2, 0,           4'b0000, 0,            0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,            0, 1, 1, 0, 2, 0,           4'b0000, 0,            0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0,            0, 1, 1, 0, 2, 0,           4'b0000, 0,            0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,            0, 1, 1, 0, 2, 0,           4'b0000, 0,            0, 0, 0);
        tbl[11] = mk(1, 0, 2, 0,            1, 1, 1, 0, 2, 0,           4'b0000, 0,            0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1111, 32'hC0DE0002, 4, 3, 32'hC0DE0002);
        tbl[13] = mk(1, 0, 2, 0,            0, 1, 0, 0, 0, 0,           4'b0000, 0,            0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1110, 32'hC0DE0002, 1, 1, 0);
        tbl[15] = mk(1, 1, 9, 32'h11,       0, 1, 1, 0, 9, 0,           4'b0000, 0,            0, 0, 0);
        tbl[16] = mk(1, 0, 9, 0,            0, 1, 0, 0, 0, 0,           4'b1111, 32'h11,       0, 0, 32'h22);
        tbl[17] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1110, 32'h11,       0, 0, 0);
        tbl[18] = mk(1, 1, 4, 32'hAAAA,     0, 1, 1, 1, 4, 32'hBBBB,    4'b0000, 0,            0, 0, 0);
        tbl[19] = mk(1, 0, 4, 0,            0, 1, 1, 0, 4, 0,           4'b1001, 32'hAAAA,     0, 0, 32'hBBBB);
        tbl[20] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1111, 32'hAAAA,     0, 0, 32'hAAAA);
        tbl[21] = mk(1, 0, 4, 0,            0, 1, 1, 1, 4, 32'hCCCC,    4'b0000, 0,            0, 0, 0);
        tbl[22] = mk(1, 0, 4, 0,            0, 1, 0, 0, 0, 0,           4'b1111, 32'hAAAA,     1, 1, 32'hCCCC);
        tbl[23] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1110, 32'hCCCC,     0, 0, 0);
        tbl[24] = mk(1, 0, 5, 0,            0, 0, 0, 0, 0, 0,           4'b1000, 32'hCCCC,     0, 0, 0);
        tbl[25] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0,           4'b1000, 32'hCCCC,     0, 0, 0);
        tbl[26] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,           4'b1110, 32'hDEADBEEF, 0, 0, 0);

        foreach (m_mv[i]) m_mv[i] = 0;
        idle();
        regce1 = 1; regce2 = 1;

        // Reset, then the sweep; a port 1 read issued mid-sweep must be ignored.
        rst = 1;
        tick();
        chk("reset_init_done", 32'(done_a), 0);
        chk("reset_dout1", dout1_a, 0);
        chk("reset_dout2", dout2_a, 0);
        chk("reset_cnt1", 32'(cnt1_a), 0);
        rst = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            en1 = (k == 5); addr1 = 3;
            tick();
            chk($sformatf("sweep_done_edge%0d", k), 32'(done_a), 32'(k == DEPTH));
        end
        idle();
        chk("sweep_ignored_read_dout1", dout1_a, 0);
        en1 = 1; addr1 = 3;
        tick();
        idle();
        tick();
        chk("first_run_read_cnt1", 32'(cnt1_a), 0);
        chk("first_run_read_cnt1_narrow", 32'(cnt1_b), 0);

        // Give every entry known data.
        for (int i = 0; i < DEPTH; i++) begin
            en1 = 1; we1 = 1; addr1 = 4'(i);
            din1 = (i == 9) ? 32'h22 : 32'hC0DE0000 + 32'(i);
            tick();
        end
        idle();
        tick();

        for (int r = 0; r < NV; r++) begin
            en1 = tbl[r].e1; we1 = tbl[r].w1; addr1 = tbl[r].a1; din1 = tbl[r].d1;
            clr1 = tbl[r].c1; regce1 = tbl[r].r1;
            en2 = tbl[r].e2; we2 = tbl[r].w2; addr2 = tbl[r].a2; din2 = tbl[r].d2;
            regce2 = 1;
            tick();
            if (tbl[r].ck[3]) chk($sformatf("vec%0d_dout1", r), dout1_a, tbl[r].ed1);
            if (tbl[r].ck[2]) chk($sformatf("vec%0d_cnt1", r), 32'(cnt1_a), 32'(tbl[r].ec1));
            if (tbl[r].ck[1]) chk($sformatf("vec%0d_cnt1_narrow", r), 32'(cnt1_b), 32'(tbl[r].ec1s));
            if (tbl[r].ck[0]) chk($sformatf("vec%0d_dout2", r), dout2_a, tbl[r].ed2);
        end
        idle();
        regce1 = 1;

        // Twenty back-to-back port 2 reads: the narrow counter must stick at 3.
        for (int i = 0; i < 20; i++) begin
            en2 = 1; addr2 = 7;
            tick();
        end
        idle();
        en1 = 1; addr1 = 7;
        tick();
        idle();
        tick();
        chk("sat_cnt1_narrow", 32'(cnt1_b), 3);
        chk("sat_cnt1_wide", 32'(cnt1_a), 15);
        chk("sat_dout1", dout1_a, 32'hC0DE0007);

        // Reset in the middle of the sweep restarts it from entry 0.
        regce1 = 0; regce2 = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1;
        tick();
        chk("midsweep_rst_dout1", dout1_a, 0);
        chk("midsweep_rst_dout2", dout2_a, 0);
        chk("midsweep_rst_cnt1", 32'(cnt1_a), 0);
        chk("midsweep_rst_init_done", 32'(done_a), 0);
        rst = 0;
        cyc = 0;
        while (!done_a && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("midsweep_restart_cycles", 32'(cyc), 32'(DEPTH));

        // Random traffic, biased onto a few entries so collisions are frequent.
        for (int i = 0; i < 600; i++) begin
            en1    = ($urandom_range(0, 2) != 0);
            we1    = ($urandom_range(0, 3) == 0);
            clr1   = ($urandom_range(0, 2) == 0);
            addr1  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            din1   = $urandom;
            regce1 = ($urandom_range(0, 4) != 0);
            en2    = ($urandom_range(0, 2) != 0);
            we2    = ($urandom_range(0, 4) == 0);
            addr2  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            din2   = $urandom;
            regce2 = ($urandom_range(0, 4) != 0);
            tick();
        end
        idle();
        regce1 = 1; regce2 = 1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
